// File: rtl/mem_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
//   Shared types for the memory port arbiter: FSM state encoding, port-owner
//   encoding, latency-counter width and the arbitration helper.
//   No ports (package).
// ----------------------------------------------------------------------------
package mem_arb_pkg;

    // Wide enough for MEM_LAT up to 15.
    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // A lone requester always wins; tie_winner only matters when both ask.
    function automatic owner_t pick_owner(input logic   if_req,
                                          input logic   d_req,
                                          input owner_t tie_winner);
        if (if_req && d_req) begin
            return tie_winner;
        end else if (d_req) begin
            return OWN_D;
        end else begin
            return OWN_IF;
        end
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the fetch port, data port and memory-side signals of the arbiter.
//   Handshake: a requester raises *_req with its address/data and holds all of
//   them steady until the matching one-cycle *_ack; the arbiter samples the
//   request only while idle. Memory side: mem_en is a one-cycle strobe and
//   mem_rdata must be valid exactly MEM_LAT cycles after it.
//   Modports:
//     slave  - the arbiter's view (requests and mem_rdata in, the rest out)
//     master - the environment's view (core ports plus memory model)
// ----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall_f;
    logic              stall_m;
    logic              busy;

    modport slave (
        input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata,
               stall_f, stall_m, busy
    );

    modport master (
        output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata,
               stall_f, stall_m, busy
    );
endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// ----------------------------------------------------------------------------
// mem_lat_counter
//   Times the ACCESS phase: loaded to 0 on grant, counts up while enabled,
//   flags terminal count when it reaches MEM_LAT.
//   Ports:
//     clk, reset  clock / asynchronous active-high reset
//     i_load      clear count to 0 (grant cycle)
//     i_en        advance count by one
//     o_tc        count == MEM_LAT (last ACCESS cycle)
// ----------------------------------------------------------------------------
module mem_lat_counter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_en,
    output logic o_tc
);
    logic [LAT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + LAT_W'(1);
        end
    end

    assign o_tc = (r_cnt == LAT_W'(MEM_LAT));
endmodule

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported, fixed-latency memory between the fetch port (IF)
//   and the data port (MEM). One transaction at a time: IDLE grants and latches
//   the request, ACCESS strobes mem_en and waits MEM_LAT cycles, RESP returns a
//   one-cycle ack with read data.
//   Ports:
//     clk, reset   clock / asynchronous active-high reset
//     bus          mem_port_arbiter_if.slave (IF port, D port, memory side,
//                  stall_f/stall_m, busy)
//     o_dbg_state  current FSM state
//   Configuration:
//     MEM_ARB_RR_EN defined   - round-robin on simultaneous requests
//     MEM_ARB_RR_EN undefined - data port always wins a tie
// ----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_port_arbiter_if.slave     bus,
    output state_t                o_dbg_state
);
    state_t            r_state;
    owner_t            r_owner;
    logic              r_we;
    logic              r_cancel;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_if_ack;
    logic              r_d_ack;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic   w_any_req;
    logic   w_load;
    logic   w_cnt_en;
    logic   w_tc;
    logic   w_if_ack;
    owner_t w_tie;
    owner_t w_win;

`ifdef MEM_ARB_RR_EN
    // Last port granted; the other one wins the next tie.
    owner_t r_last_grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= OWN_IF;
        end else if (w_load) begin
            r_last_grant <= w_win;
        end
    end

    assign w_tie = (r_last_grant == OWN_IF) ? OWN_D : OWN_IF;
`else
    // MEM stage holds the older instruction, so it wins a tie.
    assign w_tie = OWN_D;
`endif

    assign w_any_req = bus.if_req | bus.d_req;
    assign w_win     = pick_owner(bus.if_req, bus.d_req, w_tie);
    assign w_load    = (r_state == ST_IDLE) && w_any_req;
    assign w_cnt_en  = (r_state == ST_ACCESS) && !w_tc;

    mem_lat_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_counter (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load),
        .i_en   (w_cnt_en),
        .o_tc   (w_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_IF;
            r_we        <= 1'b0;
            r_cancel    <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_ack    <= 1'b0;
            r_d_ack     <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_if_ack <= 1'b0;
            r_d_ack  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cancel <= 1'b0;
                    if (w_any_req) begin
                        r_state  <= ST_ACCESS;
                        r_owner  <= w_win;
                        r_mem_en <= 1'b1;
                        if (w_win == OWN_D) begin
                            r_we        <= bus.d_we;
                            r_mem_we    <= bus.d_we;
                            r_mem_addr  <= bus.d_addr;
                            r_mem_wdata <= bus.d_wdata;
                        end else begin
                            r_we       <= 1'b0;
                            r_mem_addr <= bus.if_addr;
                        end
                    end
                end
                ST_ACCESS: begin
                    if ((r_owner == OWN_IF) && bus.if_flush) begin
                        r_cancel <= 1'b1;
                    end
                    // Last ACCESS cycle: mem_rdata is valid now.
                    if (w_tc) begin
                        r_state <= ST_RESP;
                        if (r_owner == OWN_D) begin
                            r_d_ack <= 1'b1;
                            if (!r_we) begin
                                r_d_rdata <= bus.mem_rdata;
                            end
                        end else if (!(r_cancel || bus.if_flush)) begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= bus.mem_rdata;
                        end
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // A flush arriving in the RESP cycle itself still kills the fetch ack.
    assign w_if_ack = r_if_ack & ~bus.if_flush;

    assign bus.if_ack    = w_if_ack;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_ack     = r_d_ack;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.stall_f   = bus.if_req & ~w_if_ack;
    assign bus.stall_m   = bus.d_req & ~r_d_ack;
    assign bus.busy      = (r_state != ST_IDLE);
    assign o_dbg_state   = r_state;
endmodule
